// File: rtl/pio_pkg.sv
// Shared PIO definitions: op encodings, datapath width and the 0-means-32 count decode.
package pio_pkg;

    localparam int OSR_W = 32;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_OUT  = 2'b01,
        OP_PULL = 2'b10,
        OP_MOV  = 2'b11
    } op_t;

    // 5-bit count fields encode 32 as 0
    function automatic logic [5:0] decode_count(input logic [4:0] c);
        return (c == 5'd0) ? 6'd32 : {1'b0, c};
    endfunction

endpackage

// File: rtl/osr_shift_unit.sv
// Combinational mask/shift for a shift register; n is 1..32 and n=32 empties the register.
module osr_shift_unit
    import pio_pkg::*;
(
    input  logic [OSR_W-1:0] osr,
    input  logic [5:0]       n,
    input  logic             shift_right,
    output logic [OSR_W-1:0] shifted_out,
    output logic [OSR_W-1:0] osr_next
);

    logic [OSR_W-1:0] mask;

    // Shifts by 32 or more yield zero, so n=32 needs no special case apart from the mask
    always_comb begin
        mask = (n >= 6'd32) ? '1 : ((32'd1 << n) - 32'd1);
        if (shift_right) begin
            shifted_out = osr & mask;
            osr_next    = osr >> n;
        end else begin
            shifted_out = osr >> (6'd32 - n);
            osr_next    = osr << n;
        end
    end

endmodule

// File: rtl/osr_autopull.sv
// PIO output shift register: OUT/PULL/MOV execution with TX FIFO refill and autopull stall.
module osr_autopull
    import pio_pkg::*;
#(
    parameter bit EMPTY_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             penable,
    input  logic             restart,
    input  logic [1:0]       op,
    input  logic [4:0]       bit_count,
    input  logic             shift_right,
    input  logic             auto_pull,
    input  logic [4:0]       pull_thresh,
    input  logic             pull_block,
    input  logic             pull_ifempty,
    input  logic [OSR_W-1:0] mov_data,
    input  logic [OSR_W-1:0] fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_pull,
    output logic             stall,
    output logic [OSR_W-1:0] out_data,
    output logic             out_valid,
    output logic [5:0]       shift_count
);

    localparam logic [5:0] RESET_COUNT = EMPTY_ON_RESET ? 6'd32 : 6'd0;

    logic [OSR_W-1:0] osr;
    logic [OSR_W-1:0] shifted_out;
    logic [OSR_W-1:0] osr_shifted;
    logic [5:0]       n;
    logic [5:0]       thresh;
    logic [6:0]       count_sum;
    logic [5:0]       count_after_out;
    logic             load_fifo;
    logic             load_mov;
    logic             do_out;

    assign n      = decode_count(bit_count);
    assign thresh = decode_count(pull_thresh);

    assign count_sum       = {1'b0, shift_count} + {1'b0, n};
    assign count_after_out = (count_sum > 7'd32) ? 6'd32 : count_sum[5:0];

    osr_shift_unit u_shift (
        .osr         (osr),
        .n           (n),
        .shift_right (shift_right),
        .shifted_out (shifted_out),
        .osr_next    (osr_shifted)
    );

    // reset/restart suppress the op entirely, including its FIFO pop and stall
    always_comb begin
        fifo_pull = 1'b0;
        stall     = 1'b0;
        load_fifo = 1'b0;
        load_mov  = 1'b0;
        do_out    = 1'b0;
        if (!reset && !restart && penable) begin
            case (op)
                OP_OUT: begin
                    if (auto_pull && (shift_count >= thresh)) begin
                        stall = 1'b1;
                        if (!fifo_empty) begin
                            fifo_pull = 1'b1;
                            load_fifo = 1'b1;
                        end
                    end else begin
                        do_out = 1'b1;
                    end
                end
                OP_PULL: begin
                    if (pull_ifempty && (shift_count < thresh)) begin
                        fifo_pull = 1'b0;
                    end else if (!fifo_empty) begin
                        fifo_pull = 1'b1;
                        load_fifo = 1'b1;
                    end else if (pull_block) begin
                        stall = 1'b1;
                    end else begin
                        load_mov = 1'b1;
                    end
                end
                OP_MOV:  load_mov = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            osr         <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            shift_count <= RESET_COUNT;
        end else if (restart) begin
            osr         <= '0;
            out_valid   <= 1'b0;
            shift_count <= 6'd32;
        end else begin
            out_valid <= 1'b0;
            if (load_fifo) begin
                osr         <= fifo_data;
                shift_count <= 6'd0;
            end else if (load_mov) begin
                osr         <= mov_data;
                shift_count <= 6'd0;
            end else if (do_out) begin
                osr         <= osr_shifted;
                out_data    <= shifted_out;
                out_valid   <= 1'b1;
                shift_count <= count_after_out;
            end
        end
    end

endmodule

// File: tb/tb_osr_autopull.sv
// Table-driven bench for osr_autopull with an output-data scoreboard.
module tb_osr_autopull;

    logic        clk;
    logic        reset;
    logic        penable;
    logic        restart;
    logic [1:0]  op;
    logic [4:0]  bit_count;
    logic        shift_right;
    logic        auto_pull;
    logic [4:0]  pull_thresh;
    logic        pull_block;
    logic        pull_ifempty;
    logic [31:0] mov_data;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_pull;
    logic        stall;
    logic [31:0] out_data;
    logic        out_valid;
    logic [5:0]  shift_count;

    osr_autopull #(.EMPTY_ON_RESET(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .penable      (penable),
        .restart      (restart),
        .op           (op),
        .bit_count    (bit_count),
        .shift_right  (shift_right),
        .auto_pull    (auto_pull),
        .pull_thresh  (pull_thresh),
        .pull_block   (pull_block),
        .pull_ifempty (pull_ifempty),
        .mov_data     (mov_data),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .fifo_pull    (fifo_pull),
        .stall        (stall),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .shift_count  (shift_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] NONE = 2'b00, OUT = 2'b01, PULL = 2'b10, MOV = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  bc;
        logic        sr;
        logic        ap;
        logic [4:0]  th;
        logic        blk;
        logic        ife;
        logic [31:0] mov;
        logic [31:0] fd;
        logic        fe;
        logic        e_pull;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_data;
        logic [5:0]  e_count;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;

    function automatic vec_t v(input logic [1:0] o, input logic [4:0] bc, input logic sr,
                               input logic ap, input logic [4:0] th, input logic blk,
                               input logic ife, input logic [31:0] mv, input logic [31:0] fd,
                               input logic fe, input logic ep, input logic es, input logic ev,
                               input logic [31:0] ed, input logic [5:0] ec);
        vec_t r;
        r.op = o; r.bc = bc; r.sr = sr; r.ap = ap; r.th = th; r.blk = blk; r.ife = ife;
        r.mov = mv; r.fd = fd; r.fe = fe; r.e_pull = ep; r.e_stall = es; r.e_valid = ev;
        r.e_data = ed; r.e_count = ec;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drain_output(input string name);
        if (out_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: out_valid with nothing expected, out_data 0x%08h", name, out_data);
            end else begin
                check({name, " out_data"}, out_data, exp_q.pop_front());
            end
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        string nm;
        nm = $sformatf("v%0d", idx);
        @(negedge clk);
        penable = 1'b1; restart = 1'b0;
        op = t.op; bit_count = t.bc; shift_right = t.sr; auto_pull = t.ap;
        pull_thresh = t.th; pull_block = t.blk; pull_ifempty = t.ife;
        mov_data = t.mov; fifo_data = t.fd; fifo_empty = t.fe;
        if (t.e_valid) exp_q.push_back(t.e_data);
        #1;
        check({nm, " fifo_pull"}, 32'(fifo_pull), 32'(t.e_pull));
        check({nm, " stall"}, 32'(stall), 32'(t.e_stall));
        @(posedge clk); #1;
        check({nm, " out_valid"}, 32'(out_valid), 32'(t.e_valid));
        check({nm, " shift_count"}, 32'(shift_count), 32'(t.e_count));
        drain_output(nm);
    endtask

    initial begin
        reset = 1'b1; restart = 1'b0; penable = 1'b1; op = OUT; bit_count = 5'd8;
        shift_right = 1'b1; auto_pull = 1'b1; pull_thresh = 5'd0; pull_block = 1'b1;
        pull_ifempty = 1'b0; mov_data = 32'h0; fifo_data = 32'h1234_0000; fifo_empty = 1'b0;

        // reset wins over an op that would otherwise pull and stall
        repeat (3) begin
            @(negedge clk);
            check("reset fifo_pull", 32'(fifo_pull), 32'd0);
            check("reset stall", 32'(stall), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0; penable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("post-reset%0d count", i), 32'(shift_count), 32'd32);
            check($sformatf("post-reset%0d out_valid", i), 32'(out_valid), 32'd0);
            check($sformatf("post-reset%0d stall", i), 32'(stall), 32'd0);
            check($sformatf("post-reset%0d out_data", i), out_data, 32'd0);
        end

        //                 op   bc     sr ap th     blk ife mov           fd            fe pull st val data          count
        vecs.push_back(v(MOV,  5'd0,  1, 0, 5'd0,  0, 0, 32'hDEADBEEF, 32'h0,        1, 0, 0, 0, 32'h0,        6'd0));
        vecs.push_back(v(OUT,  5'd8,  1, 0, 5'd0,  0, 0, 32'h0,        32'h0,        1, 0, 0, 1, 32'hEF,       6'd8));
        vecs.push_back(v(OUT,  5'd4,  0, 0, 5'd0,  0, 0, 32'h0,        32'h0,        1, 0, 0, 1, 32'h0,        6'd12));
        vecs.push_back(v(OUT,  5'd0,  1, 0, 5'd0,  0, 0, 32'h0,        32'h0,        1, 0, 0, 1, 32'h0DEADBE0, 6'd32));
        vecs.push_back(v(MOV,  5'd0,  1, 0, 5'd0,  0, 0, 32'h12345678, 32'h0,        1, 0, 0, 0, 32'h0,        6'd0));
        vecs.push_back(v(OUT,  5'd0,  0, 0, 5'd0,  0, 0, 32'h0,        32'h0,        1, 0, 0, 1, 32'h12345678, 6'd32));
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(OUT, 5'd16, 1, 1, 5'd0, 0, 0, 32'h0,     32'h0,        1, 0, 1, 0, 32'h0,        6'd32));
        vecs.push_back(v(OUT,  5'd16, 1, 1, 5'd0,  0, 0, 32'h0,        32'hA5A5A5A5, 0, 1, 1, 0, 32'h0,        6'd0));
        vecs.push_back(v(OUT,  5'd16, 1, 1, 5'd0,  0, 0, 32'h0,        32'h11111111, 0, 0, 0, 1, 32'hA5A5,     6'd16));
        vecs.push_back(v(PULL, 5'd0,  1, 0, 5'd0,  0, 0, 32'h55,       32'h0,        1, 0, 0, 0, 32'h0,        6'd0));
        vecs.push_back(v(OUT,  5'd8,  1, 0, 5'd0,  0, 0, 32'h0,        32'h0,        1, 0, 0, 1, 32'h55,       6'd8));
        vecs.push_back(v(PULL, 5'd0,  1, 0, 5'd0,  1, 0, 32'h99,       32'h0,        1, 0, 1, 0, 32'h0,        6'd8));
        vecs.push_back(v(PULL, 5'd0,  1, 0, 5'd0,  1, 0, 32'h99,       32'h0,        1, 0, 1, 0, 32'h0,        6'd8));
        vecs.push_back(v(PULL, 5'd0,  1, 0, 5'd0,  1, 0, 32'h99,       32'hCAFEF00D, 0, 1, 0, 0, 32'h0,        6'd0));
        vecs.push_back(v(OUT,  5'd16, 1, 0, 5'd0,  0, 0, 32'h0,        32'h0,        1, 0, 0, 1, 32'hF00D,     6'd16));
        vecs.push_back(v(MOV,  5'd0,  1, 0, 5'd0,  0, 0, 32'hFF,       32'h0,        0, 0, 0, 0, 32'h0,        6'd0));
        vecs.push_back(v(OUT,  5'd8,  1, 0, 5'd0,  0, 0, 32'h0,        32'h0,        1, 0, 0, 1, 32'hFF,       6'd8));
        vecs.push_back(v(PULL, 5'd0,  1, 0, 5'd16, 0, 1, 32'h0,        32'h12,       0, 0, 0, 0, 32'h0,        6'd8));
        vecs.push_back(v(OUT,  5'd8,  1, 0, 5'd0,  0, 0, 32'h0,        32'h0,        1, 0, 0, 1, 32'h0,        6'd16));
        vecs.push_back(v(PULL, 5'd0,  1, 0, 5'd16, 0, 1, 32'h0,        32'h77,       0, 1, 0, 0, 32'h0,        6'd0));
        vecs.push_back(v(OUT,  5'd8,  1, 0, 5'd0,  0, 0, 32'h0,        32'h0,        1, 0, 0, 1, 32'h77,       6'd8));
        vecs.push_back(v(OUT,  5'd1,  1, 1, 5'd9,  0, 0, 32'h0,        32'h3,        0, 0, 0, 1, 32'h0,        6'd9));
        vecs.push_back(v(OUT,  5'd2,  1, 1, 5'd9,  0, 0, 32'h0,        32'h3,        0, 1, 1, 0, 32'h0,        6'd0));
        vecs.push_back(v(OUT,  5'd2,  1, 1, 5'd9,  0, 0, 32'h0,        32'h9,        0, 0, 0, 1, 32'h3,        6'd2));
        vecs.push_back(v(MOV,  5'd0,  1, 0, 5'd0,  0, 0, 32'hFFFFFFFF, 32'h0,        0, 0, 0, 0, 32'h0,        6'd0));
        vecs.push_back(v(OUT,  5'd20, 1, 0, 5'd0,  0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 32'hFFFFF,    6'd20));
        vecs.push_back(v(OUT,  5'd16, 1, 0, 5'd0,  0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 32'hFFF,      6'd32));
        vecs.push_back(v(NONE, 5'd8,  1, 1, 5'd0,  0, 0, 32'h0,        32'h42,       0, 0, 0, 0, 32'h0,        6'd32));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // penable low: an OUT that would autopull must change nothing
        @(negedge clk);
        penable = 1'b0; op = OUT; auto_pull = 1'b1; pull_thresh = 5'd0; fifo_empty = 1'b0;
        fifo_data = 32'hBAD0BAD0; bit_count = 5'd4;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("idle%0d fifo_pull", i), 32'(fifo_pull), 32'd0);
            check($sformatf("idle%0d stall", i), 32'(stall), 32'd0);
            @(posedge clk); #1;
            check($sformatf("idle%0d count", i), 32'(shift_count), 32'd32);
            check($sformatf("idle%0d out_valid", i), 32'(out_valid), 32'd0);
            @(negedge clk);
        end

        // restart coincident with a completing OUT discards it
        apply(v(MOV, 5'd0, 1, 0, 5'd0, 0, 0, 32'h87654321, 32'h0, 1, 0, 0, 0, 32'h0, 6'd0), 100);
        @(negedge clk);
        restart = 1'b1; penable = 1'b1; op = OUT; auto_pull = 1'b0; bit_count = 5'd8;
        shift_right = 1'b1; fifo_empty = 1'b0;
        #1;
        check("restart fifo_pull", 32'(fifo_pull), 32'd0);
        check("restart stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check("restart count", 32'(shift_count), 32'd32);
        check("restart out_valid", 32'(out_valid), 32'd0);
        drain_output("restart");
        apply(v(OUT, 5'd0, 1, 0, 5'd0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 1, 32'h0, 6'd32), 101);

        @(negedge clk);
        penable = 1'b0;
        check("scoreboard leftover", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
